except_collect: RTL and testbench



---
 rtl/except_collect_pkg.sv | 30 +++
 rtl/except_collect_if.sv | 50 +++++
 rtl/except_collect_detect.sv | 33 +++
 rtl/except_collect.sv | 94 +++++++++
 tb/tb_except_collect.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/except_collect_pkg.sv
// rtl/except_collect_pkg.sv - shared widths, excepttype codes and misalignment helper
package except_collect_pkg;

  localparam int EXCEPT_WD = 44;

  localparam logic [31:0] EXC_PCASSERT    = 32'h4;
  localparam logic [31:0] EXC_LOADASSERT  = 32'h5;
  localparam logic [31:0] EXC_STOREASSERT = 32'h6;
  localparam logic [31:0] EXC_SYSCALL     = 32'h8;
  localparam logic [31:0] EXC_BREAK       = 32'h9;
  localparam logic [31:0] EXC_INVALIDINST = 32'ha;
  localparam logic [31:0] EXC_OV          = 32'hc;
  localparam logic [31:0] EXC_ERET        = 32'he;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  // Byte accesses (and the unused encoding 3) can never be misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (mem_size_e'(size))
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/except_collect_if.sv
// rtl/except_collect_if.sv - EX-side lane inputs and CP0/MEM-side registered outputs
interface except_collect_if;
  import except_collect_pkg::*;

  logic                 ex_valid_1, ex_valid_2;
  logic [31:0]          ex_pc_1, ex_pc_2;
  logic                 ex_is_branch_1, ex_is_branch_2;
  logic                 ex_inst_invalid_1, ex_inst_invalid_2;
  logic                 ex_is_syscall_1, ex_is_syscall_2;
  logic                 ex_is_break_1, ex_is_break_2;
  logic                 ex_is_eret_1, ex_is_eret_2;
  logic                 ex_ov_1, ex_ov_2;
  logic                 ex_mem_re_1, ex_mem_re_2;
  logic                 ex_mem_we_1, ex_mem_we_2;
  logic [1:0]           ex_mem_size_1, ex_mem_size_2;
  logic [31:0]          ex_mem_addr_1, ex_mem_addr_2;
  logic                 ex_cp0_we_1, ex_cp0_we_2;
  logic [4:0]           ex_cp0_waddr_1, ex_cp0_waddr_2;
  logic [4:0]           ex_cp0_raddr_1, ex_cp0_raddr_2;
  logic [31:0]          ex_rt_rdata_1, ex_rt_rdata_2;

  logic [EXCEPT_WD-1:0] exceptinfo_o1, exceptinfo_o2;
  logic [31:0]          current_pc_o1, current_pc_o2;
  logic [31:0]          rt_rdata_o1, rt_rdata_o2;
  logic                 mem_kill_o1, mem_kill_o2;
  logic                 valid_o1, valid_o2;

  modport master (
    output ex_valid_1, ex_valid_2, ex_pc_1, ex_pc_2, ex_is_branch_1, ex_is_branch_2,
           ex_inst_invalid_1, ex_inst_invalid_2, ex_is_syscall_1, ex_is_syscall_2,
           ex_is_break_1, ex_is_break_2, ex_is_eret_1, ex_is_eret_2, ex_ov_1, ex_ov_2,
           ex_mem_re_1, ex_mem_re_2, ex_mem_we_1, ex_mem_we_2, ex_mem_size_1, ex_mem_size_2,
           ex_mem_addr_1, ex_mem_addr_2, ex_cp0_we_1, ex_cp0_we_2, ex_cp0_waddr_1,
           ex_cp0_waddr_2, ex_cp0_raddr_1, ex_cp0_raddr_2, ex_rt_rdata_1, ex_rt_rdata_2,
    input  exceptinfo_o1, exceptinfo_o2, current_pc_o1, current_pc_o2,
           rt_rdata_o1, rt_rdata_o2, mem_kill_o1, mem_kill_o2, valid_o1, valid_o2
  );

  modport slave (
    input  ex_valid_1, ex_valid_2, ex_pc_1, ex_pc_2, ex_is_branch_1, ex_is_branch_2,
           ex_inst_invalid_1, ex_inst_invalid_2, ex_is_syscall_1, ex_is_syscall_2,
           ex_is_break_1, ex_is_break_2, ex_is_eret_1, ex_is_eret_2, ex_ov_1, ex_ov_2,
           ex_mem_re_1, ex_mem_re_2, ex_mem_we_1, ex_mem_we_2, ex_mem_size_1, ex_mem_size_2,
           ex_mem_addr_1, ex_mem_addr_2, ex_cp0_we_1, ex_cp0_we_2, ex_cp0_waddr_1,
           ex_cp0_waddr_2, ex_cp0_raddr_1, ex_cp0_raddr_2, ex_rt_rdata_1, ex_rt_rdata_2,
    output exceptinfo_o1, exceptinfo_o2, current_pc_o1, current_pc_o2,
           rt_rdata_o1, rt_rdata_o2, mem_kill_o1, mem_kill_o2, valid_o1, valid_o2
  );

endinterface

// File: rtl/except_collect_detect.sv
// rtl/except_collect_detect.sv - per-lane excepttype priority encoder (combinational)
module except_detect
  import except_collect_pkg::*;
(
  input  logic [1:0]  pc_lo,
  input  logic        inst_invalid,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_eret,
  input  logic        ov,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] excepttype
);

  logic bad_addr;

  always_comb begin
    bad_addr = misaligned(mem_size, addr_lo);
    excepttype = '0;
    if (pc_lo != 2'b00)          excepttype = EXC_PCASSERT;
    else if (inst_invalid)       excepttype = EXC_INVALIDINST;
    else if (is_syscall)         excepttype = EXC_SYSCALL;
    else if (is_break)           excepttype = EXC_BREAK;
    else if (is_eret)            excepttype = EXC_ERET;
    else if (ov)                 excepttype = EXC_OV;
    else if (mem_re && bad_addr) excepttype = EXC_LOADASSERT;
    else if (mem_we && bad_addr) excepttype = EXC_STOREASSERT;
  end

endmodule

// File: rtl/except_collect.sv
// rtl/except_collect.sv - EX->MEM exception collection with lane-2 kill and delay-slot tracking
module except_collect
  import except_collect_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  except_collect_if.slave   bus
);

  logic [31:0]          det_1, det_2, exc_1, exc_2;
  logic                 live_2, ds_pending, ds_next;
  logic [EXCEPT_WD-1:0] info_1_d, info_2_d;
  logic [31:0]          rt_1_d, rt_2_d;

  except_detect u_detect_1 (
    .pc_lo(bus.ex_pc_1[1:0]), .inst_invalid(bus.ex_inst_invalid_1),
    .is_syscall(bus.ex_is_syscall_1), .is_break(bus.ex_is_break_1),
    .is_eret(bus.ex_is_eret_1), .ov(bus.ex_ov_1), .mem_re(bus.ex_mem_re_1),
    .mem_we(bus.ex_mem_we_1), .mem_size(bus.ex_mem_size_1),
    .addr_lo(bus.ex_mem_addr_1[1:0]), .excepttype(det_1)
  );

  except_detect u_detect_2 (
    .pc_lo(bus.ex_pc_2[1:0]), .inst_invalid(bus.ex_inst_invalid_2),
    .is_syscall(bus.ex_is_syscall_2), .is_break(bus.ex_is_break_2),
    .is_eret(bus.ex_is_eret_2), .ov(bus.ex_ov_2), .mem_re(bus.ex_mem_re_2),
    .mem_we(bus.ex_mem_we_2), .mem_size(bus.ex_mem_size_2),
    .addr_lo(bus.ex_mem_addr_2[1:0]), .excepttype(det_2)
  );

  always_comb begin
    exc_1  = bus.ex_valid_1 ? det_1 : '0;
    exc_2  = bus.ex_valid_2 ? det_2 : '0;
    // Precise exceptions: a faulting older lane squashes the younger one.
    live_2 = bus.ex_valid_2 && (exc_1 == '0);

    info_1_d = '0;
    rt_1_d   = '0;
    if (bus.ex_valid_1) begin
      info_1_d = {ds_pending, bus.ex_cp0_we_1 && (exc_1 == '0), bus.ex_cp0_waddr_1,
                  bus.ex_cp0_raddr_1, exc_1};
      rt_1_d   = (exc_1 == EXC_LOADASSERT || exc_1 == EXC_STOREASSERT) ?
                 bus.ex_mem_addr_1 : bus.ex_rt_rdata_1;
    end

    info_2_d = '0;
    rt_2_d   = '0;
    if (live_2) begin
      info_2_d = {bus.ex_valid_1 && bus.ex_is_branch_1, bus.ex_cp0_we_2 && (exc_2 == '0),
                  bus.ex_cp0_waddr_2, bus.ex_cp0_raddr_2, exc_2};
      rt_2_d   = (exc_2 == EXC_LOADASSERT || exc_2 == EXC_STOREASSERT) ?
                 bus.ex_mem_addr_2 : bus.ex_rt_rdata_2;
    end

    // A bubble must not clear a pending delay slot.
    ds_next = ds_pending;
    if ((bus.ex_valid_2 && bus.ex_is_branch_2) ||
        (bus.ex_valid_1 && bus.ex_is_branch_1 && !bus.ex_valid_2))
      ds_next = 1'b1;
    else if (bus.ex_valid_1)
      ds_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      bus.exceptinfo_o1 <= '0;
      bus.exceptinfo_o2 <= '0;
      bus.current_pc_o1 <= '0;
      bus.current_pc_o2 <= '0;
      bus.rt_rdata_o1   <= '0;
      bus.rt_rdata_o2   <= '0;
      bus.mem_kill_o1   <= 1'b0;
      bus.mem_kill_o2   <= 1'b0;
      bus.valid_o1      <= 1'b0;
      bus.valid_o2      <= 1'b0;
      ds_pending        <= 1'b0;
    end else if (!stall) begin
      bus.exceptinfo_o1 <= info_1_d;
      bus.exceptinfo_o2 <= info_2_d;
      bus.current_pc_o1 <= bus.ex_valid_1 ? bus.ex_pc_1 : 32'h0;
      bus.current_pc_o2 <= live_2 ? bus.ex_pc_2 : 32'h0;
      bus.rt_rdata_o1   <= rt_1_d;
      bus.rt_rdata_o2   <= rt_2_d;
      bus.mem_kill_o1   <= !bus.ex_valid_1 || (exc_1 != '0);
      bus.mem_kill_o2   <= !live_2 || (exc_2 != '0);
      bus.valid_o1      <= bus.ex_valid_1;
      bus.valid_o2      <= live_2;
      ds_pending        <= ds_next;
    end
  end

endmodule

// File: tb/tb_except_collect.sv
// tb/tb_except_collect.sv - directed and random checks of except_collect against a reference model
module tb_except_collect;

  logic clk = 1'b0;
  logic rst, stall, flush;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  except_collect_if bus();

  except_collect dut (.clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus));

  typedef struct {
    logic        valid, br, inv, sys, brk, eret, ov, re, we, cp0_we;
    logic [31:0] pc, addr, rt;
    logic [1:0]  size;
    logic [4:0]  waddr, raddr;
  } lane_t;

  lane_t       l1, l2;
  logic [43:0] e_info1, e_info2;
  logic [31:0] e_pc1, e_pc2, e_rt1, e_rt2;
  logic        e_kill1, e_kill2, e_v1, e_v2, e_ds;

  function automatic lane_t empty_lane();
    lane_t l;
    l.valid = 0; l.br = 0; l.inv = 0; l.sys = 0; l.brk = 0; l.eret = 0; l.ov = 0;
    l.re = 0; l.we = 0; l.cp0_we = 0; l.pc = 0; l.addr = 0; l.rt = 0; l.size = 0;
    l.waddr = 0; l.raddr = 0;
    return l;
  endfunction

  function automatic lane_t rand_lane();
    lane_t l;
    l.valid  = $urandom_range(0, 3) != 0;
    l.br     = $urandom_range(0, 3) == 0;
    l.inv    = $urandom_range(0, 15) == 0;
    l.sys    = $urandom_range(0, 15) == 0;
    l.brk    = $urandom_range(0, 15) == 0;
    l.eret   = $urandom_range(0, 15) == 0;
    l.ov     = $urandom_range(0, 15) == 0;
    l.re     = $urandom_range(0, 2) == 0;
    l.we     = $urandom_range(0, 2) == 0;
    l.cp0_we = $urandom_range(0, 3) == 0;
    l.pc     = ($urandom & 32'hffff_fffc) | (($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0);
    l.addr   = $urandom;
    l.rt     = $urandom;
    l.size   = 2'($urandom_range(0, 2));
    l.waddr  = 5'($urandom_range(0, 31));
    l.raddr  = 5'($urandom_range(0, 31));
    return l;
  endfunction

  function automatic logic [31:0] model_exc(lane_t l);
    int bytes;
    bytes = (l.size == 0) ? 1 : (l.size == 1) ? 2 : (l.size == 2) ? 4 : 1;
    if (!l.valid)                    return 32'h0;
    if (l.pc % 4 != 0)               return 32'h4;
    if (l.inv)                       return 32'ha;
    if (l.sys)                       return 32'h8;
    if (l.brk)                       return 32'h9;
    if (l.eret)                      return 32'he;
    if (l.ov)                        return 32'hc;
    if (l.re && l.addr % bytes != 0) return 32'h5;
    if (l.we && l.addr % bytes != 0) return 32'h6;
    return 32'h0;
  endfunction

  task automatic model_clear();
    e_info1 = 0; e_info2 = 0; e_pc1 = 0; e_pc2 = 0; e_rt1 = 0; e_rt2 = 0;
    e_kill1 = 0; e_kill2 = 0; e_v1 = 0; e_v2 = 0; e_ds = 0;
  endtask

  task automatic model_step();
    logic [31:0] x1, x2;
    logic        alive2;
    if (!rst || flush) begin
      model_clear();
    end else if (!stall) begin
      x1 = model_exc(l1);
      x2 = model_exc(l2);
      alive2 = l2.valid && x1 == 0;
      e_v1 = l1.valid;  e_kill1 = !l1.valid || x1 != 0;
      e_info1 = l1.valid ? {e_ds, l1.cp0_we && x1 == 0, l1.waddr, l1.raddr, x1} : 44'h0;
      e_pc1 = l1.valid ? l1.pc : 0;
      e_rt1 = !l1.valid ? 0 : (x1 == 5 || x1 == 6) ? l1.addr : l1.rt;
      e_v2 = alive2;    e_kill2 = !alive2 || x2 != 0;
      e_info2 = alive2 ? {l1.valid && l1.br, l2.cp0_we && x2 == 0, l2.waddr, l2.raddr, x2} : 44'h0;
      e_pc2 = alive2 ? l2.pc : 0;
      e_rt2 = !alive2 ? 0 : (x2 == 5 || x2 == 6) ? l2.addr : l2.rt;
      if ((l2.valid && l2.br) || (l1.valid && l1.br && !l2.valid)) e_ds = 1;
      else if (l1.valid)                                           e_ds = 0;
    end
  endtask

  task automatic drive();
    bus.ex_valid_1 = l1.valid;  bus.ex_valid_2 = l2.valid;
    bus.ex_pc_1 = l1.pc;        bus.ex_pc_2 = l2.pc;
    bus.ex_is_branch_1 = l1.br; bus.ex_is_branch_2 = l2.br;
    bus.ex_inst_invalid_1 = l1.inv; bus.ex_inst_invalid_2 = l2.inv;
    bus.ex_is_syscall_1 = l1.sys;   bus.ex_is_syscall_2 = l2.sys;
    bus.ex_is_break_1 = l1.brk;     bus.ex_is_break_2 = l2.brk;
    bus.ex_is_eret_1 = l1.eret;     bus.ex_is_eret_2 = l2.eret;
    bus.ex_ov_1 = l1.ov;            bus.ex_ov_2 = l2.ov;
    bus.ex_mem_re_1 = l1.re;        bus.ex_mem_re_2 = l2.re;
    bus.ex_mem_we_1 = l1.we;        bus.ex_mem_we_2 = l2.we;
    bus.ex_mem_size_1 = l1.size;    bus.ex_mem_size_2 = l2.size;
    bus.ex_mem_addr_1 = l1.addr;    bus.ex_mem_addr_2 = l2.addr;
    bus.ex_cp0_we_1 = l1.cp0_we;    bus.ex_cp0_we_2 = l2.cp0_we;
    bus.ex_cp0_waddr_1 = l1.waddr;  bus.ex_cp0_waddr_2 = l2.waddr;
    bus.ex_cp0_raddr_1 = l1.raddr;  bus.ex_cp0_raddr_2 = l2.raddr;
    bus.ex_rt_rdata_1 = l1.rt;      bus.ex_rt_rdata_2 = l2.rt;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    drive();
    @(posedge clk);
    #1;
    check("info1", 64'(bus.exceptinfo_o1), 64'(e_info1));
    check("info2", 64'(bus.exceptinfo_o2), 64'(e_info2));
    check("pc1",   64'(bus.current_pc_o1), 64'(e_pc1));
    check("pc2",   64'(bus.current_pc_o2), 64'(e_pc2));
    check("rt1",   64'(bus.rt_rdata_o1),   64'(e_rt1));
    check("rt2",   64'(bus.rt_rdata_o2),   64'(e_rt2));
    check("kill1", 64'(bus.mem_kill_o1),   64'(e_kill1));
    check("kill2", 64'(bus.mem_kill_o2),   64'(e_kill2));
    check("v1",    64'(bus.valid_o1),      64'(e_v1));
    check("v2",    64'(bus.valid_o2),      64'(e_v2));
  endtask

  initial begin
    rst = 0; stall = 0; flush = 0;
    l1 = empty_lane(); l2 = empty_lane();
    model_clear();
    tick();
    check("reset_info1", 64'(bus.exceptinfo_o1), 64'h0);
    check("reset_kill1", 64'(bus.mem_kill_o1), 64'h0);
    rst = 1;

    // Misaligned word load in lane 1 kills lane 2.
    l1 = empty_lane(); l1.valid = 1; l1.pc = 32'hbfc00100; l1.re = 1; l1.size = 2; l1.addr = 32'h1002;
    l2 = empty_lane(); l2.valid = 1; l2.pc = 32'hbfc00104;
    tick();
    check("ld_exc", 64'(bus.exceptinfo_o1[31:0]), 64'h5);
    check("ld_rt", 64'(bus.rt_rdata_o1), 64'h1002);
    check("ld_kill1", 64'(bus.mem_kill_o1), 64'h1);
    check("ld_v2", 64'(bus.valid_o2), 64'h0);
    check("ld_info2", 64'(bus.exceptinfo_o2), 64'h0);

    // Branch in lane 1, syscall in its delay slot (lane 2).
    l1 = empty_lane(); l1.valid = 1; l1.br = 1; l1.pc = 32'h80000000;
    l2 = empty_lane(); l2.valid = 1; l2.sys = 1; l2.pc = 32'h80000004;
    tick();
    check("ds2_bit", 64'(bus.exceptinfo_o2[43]), 64'h1);
    check("ds2_exc", 64'(bus.exceptinfo_o2[31:0]), 64'h8);
    check("ds2_pc", 64'(bus.current_pc_o2), 64'h80000004);

    // Lane 2 branch, bubble, then ERET in lane 1 sits in the delay slot.
    l1 = empty_lane(); l2 = empty_lane(); l2.valid = 1; l2.br = 1; l2.pc = 32'h80000010;
    tick();
    l2 = empty_lane();
    tick();
    l1.valid = 1; l1.eret = 1; l1.pc = 32'h80000014;
    tick();
    check("eret_ds", 64'(bus.exceptinfo_o1[43]), 64'h1);
    check("eret_exc", 64'(bus.exceptinfo_o1[31:0]), 64'he);

    // mtc0 suppressed by overflow, then allowed.
    l1 = empty_lane(); l1.valid = 1; l1.pc = 32'h80000020; l1.cp0_we = 1; l1.waddr = 12;
    l1.rt = 32'h0000ff01; l1.ov = 1;
    tick();
    check("mtc0_ov_we", 64'(bus.exceptinfo_o1[42]), 64'h0);
    check("mtc0_ov_exc", 64'(bus.exceptinfo_o1[31:0]), 64'hc);
    l1.ov = 0;
    tick();
    check("mtc0_we", 64'(bus.exceptinfo_o1[42]), 64'h1);
    check("mtc0_waddr", 64'(bus.exceptinfo_o1[41:37]), 64'd12);
    check("mtc0_rt", 64'(bus.rt_rdata_o1), 64'h0000ff01);

    // Stall freezes outputs; flush overrides stall and drops the pending slot.
    l1 = empty_lane(); l1.valid = 1; l1.pc = 32'h80001000;
    l2 = empty_lane(); l2.valid = 1; l2.br = 1; l2.pc = 32'h80001004;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      l1 = rand_lane(); l2 = rand_lane();
      tick();
      check("stall_pc1", 64'(bus.current_pc_o1), 64'h80001000);
    end
    flush = 1;
    tick();
    check("flush_v1", 64'(bus.valid_o1), 64'h0);
    check("flush_pc1", 64'(bus.current_pc_o1), 64'h0);
    stall = 0; flush = 0;
    l1 = empty_lane(); l1.valid = 1; l1.eret = 1; l1.pc = 32'h80002000; l2 = empty_lane();
    tick();
    check("flush_ds", 64'(bus.exceptinfo_o1[43]), 64'h0);

    // Priority and store misalignment.
    l1 = empty_lane(); l1.valid = 1; l1.pc = 32'h80000001; l1.inv = 1;
    tick();
    check("pc_prio", 64'(bus.exceptinfo_o1[31:0]), 64'h4);
    l1 = empty_lane(); l1.valid = 1; l1.pc = 32'h80000030; l1.we = 1; l1.size = 1; l1.addr = 32'h2001;
    tick();
    check("st_half", 64'(bus.exceptinfo_o1[31:0]), 64'h6);

    // Reset mid-stream loses a pending delay slot.
    l1 = empty_lane(); l2 = empty_lane(); l2.valid = 1; l2.br = 1; l2.pc = 32'h80000040;
    tick();
    rst = 0; l1 = rand_lane(); l2 = rand_lane();
    tick();
    check("rst_v2", 64'(bus.valid_o2), 64'h0);
    check("rst_kill2", 64'(bus.mem_kill_o2), 64'h0);
    rst = 1;
    l1 = empty_lane(); l1.valid = 1; l1.eret = 1; l1.pc = 32'h80000050; l2 = empty_lane();
    tick();
    check("rst_ds", 64'(bus.exceptinfo_o1[43]), 64'h0);

    // Random traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      l1 = rand_lane(); l2 = rand_lane();
      stall = $urandom_range(0, 9) == 0;
      flush = $urandom_range(0, 19) == 0;
      rst   = $urandom_range(0, 49) != 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
